mem_responder: RTL and testbench

Multi-cycle memory responder for the processor memory port. Accepts `memread`/`memwrite` requests on `adr`/`writedata`, services them from an internal word array after a fixed, parameterised latency, and returns `memdata` with a one-cycle `ready` pulse. It sits opposite the processor in the processor-plus-memory top level and replaces the zero-wait memory when slow-memory behaviour must be exercised.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_responder_if.sv | 34 +++
 rtl/mem_array.sv | 23 ++
 rtl/mem_responder.sv | 96 +++++++++
 tb/tb_mem_responder.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and limits for the multi-cycle memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int MEM_MAX_LATENCY = 15;
    localparam int MEM_CNT_W       = 4;

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - processor memory port bundle between initiator and responder
interface mem_responder_if #(
    parameter int WIDTH = 8
);

    logic             memread;
    logic             memwrite;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] memdata;
    logic             ready;
    logic             err;

    modport master (
        output memread,
        output memwrite,
        output adr,
        output writedata,
        input  memdata,
        input  ready,
        input  err
    );

    modport slave (
        input  memread,
        input  memwrite,
        input  adr,
        input  writedata,
        output memdata,
        output ready,
        output err
    );

endinterface

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word array, synchronous write and combinational read
module mem_array #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Contents are intentionally left unreset; they are undefined until written.
    logic [WIDTH-1:0] mem [0:(1 << WIDTH) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[a] <= d;
        end
    end

    assign q = mem[a];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency memory responder with one-cycle ready pulse
module mem_responder
    import mem_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    if (LATENCY < 1 || LATENCY > MEM_MAX_LATENCY) begin : g_latency_check
        $fatal(1, "mem_responder: LATENCY %0d outside 1..%0d", LATENCY, MEM_MAX_LATENCY);
    end

    localparam logic [MEM_CNT_W-1:0] CNT_LOAD = MEM_CNT_W'(LATENCY - 1);
    localparam logic [MEM_CNT_W-1:0] CNT_LAST = MEM_CNT_W'(1);

    mem_state_t           state;
    logic [MEM_CNT_W-1:0] cnt;
    logic [WIDTH-1:0]     lat_adr;
    logic [WIDTH-1:0]     lat_wd;
    logic                 lat_wr;
    logic [WIDTH-1:0]     memdata_r;
    logic                 ready_r;
    logic                 err_r;
    logic                 array_we;
    logic [WIDTH-1:0]     array_q;

    // The array is only touched on the DONE edge, so a reset that drops the
    // state back to IDLE mid-transaction can never commit the pending write.
    assign array_we = (state == DONE) && lat_wr;

    mem_array #(
        .WIDTH (WIDTH)
    ) u_array (
        .clk (clk),
        .we  (array_we),
        .a   (lat_adr),
        .d   (lat_wd),
        .q   (array_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_adr   <= '0;
            lat_wd    <= '0;
            lat_wr    <= 1'b0;
            memdata_r <= '0;
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.memread || bus.memwrite) begin
                        lat_adr <= bus.adr;
                        lat_wd  <= bus.writedata;
                        lat_wr  <= bus.memwrite;
                        if (bus.memread && bus.memwrite) begin
                            err_r <= 1'b1;
                        end
                        cnt   <= CNT_LOAD;
                        state <= (LATENCY == 1) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Completion edge: commit or load memdata and raise ready together,
                    // so ready is seen exactly LATENCY edges after acceptance.
                    ready_r <= 1'b1;
                    if (!lat_wr) begin
                        memdata_r <= array_q;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.memdata = memdata_r;
    assign bus.ready   = ready_r;
    assign bus.err     = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench over three responders with latencies 2, 1 and 4
module tb_mem_responder;

    typedef struct {
        int         dut;
        bit         is_read;
        bit         differ;
        logic [7:0] data;
        longint     due;
    } exp_t;

    logic            clk;
    logic [2:0]      rst_v;
    logic [2:0]      rd_v;
    logic [2:0]      wr_v;
    logic [2:0][7:0] adr_v;
    logic [2:0][7:0] wd_v;
    logic [2:0]      ready_v;
    logic [2:0]      err_v;
    logic [2:0][7:0] md_v;

    longint     cyc;
    int         tests;
    int         fails;
    exp_t       exp_q[$];
    logic [7:0] ref_mem [3][256];
    bit         ref_ok [3][256];
    logic [7:0] ref_md [3];
    bit         md_known [3];
    longint     ref_err_cyc [3];
    logic [7:0] wlist[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder_if #(.WIDTH(8)) bus ();

        mem_responder #(
            .WIDTH   (8),
            .LATENCY ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
        ) u_dut (
            .clk   (clk),
            .reset (rst_v[g]),
            .bus   (bus)
        );

        assign bus.memread   = rd_v[g];
        assign bus.memwrite  = wr_v[g];
        assign bus.adr       = adr_v[g];
        assign bus.writedata = wd_v[g];
        assign ready_v[g]    = bus.ready;
        assign err_v[g]      = bus.err;
        assign md_v[g]       = bus.memdata;
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: pops expectations on every ready pulse and checks held outputs each cycle.
    initial begin
        exp_t e;
        bit   exp_err;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (ready_v[d]) begin
                    tests++;
                    if (!rst_v[d]) begin
                        fails++;
                        $display("FAIL ready_in_reset dut=%0d got ready=1 want 0", d);
                    end else if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_ready dut=%0d cycle=%0d got ready=1 want 0", d, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.dut != d || e.due != cyc) begin
                            fails++;
                            $display("FAIL ready_timing got dut=%0d cycle=%0d want dut=%0d cycle=%0d",
                                     d, cyc, e.dut, e.due);
                        end
                        if (e.is_read) begin
                            tests++;
                            if (e.differ) begin
                                if (md_v[d] == e.data) begin
                                    fails++;
                                    $display("FAIL read_unwritten dut=%0d got %02h want anything but %02h",
                                             d, md_v[d], e.data);
                                end
                                md_known[d] = 1'b0;
                            end else begin
                                if (md_v[d] !== e.data) begin
                                    fails++;
                                    $display("FAIL read_data dut=%0d got %02h want %02h", d, md_v[d], e.data);
                                end
                                ref_md[d]   = e.data;
                                md_known[d] = 1'b1;
                            end
                        end
                    end
                end
                if (md_known[d]) begin
                    tests++;
                    if (md_v[d] !== ref_md[d]) begin
                        fails++;
                        $display("FAIL memdata_hold dut=%0d cycle=%0d got %02h want %02h",
                                 d, cyc, md_v[d], ref_md[d]);
                    end
                end
                exp_err = (ref_err_cyc[d] >= 0) && (cyc >= ref_err_cyc[d]);
                tests++;
                if (err_v[d] !== exp_err) begin
                    fails++;
                    $display("FAIL err_flag dut=%0d cycle=%0d got %0b want %0b", d, cyc, err_v[d], exp_err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int d);
        rd_v[d]  = 1'b0;
        wr_v[d]  = 1'b0;
        adr_v[d] = 8'($urandom);
        wd_v[d]  = 8'($urandom);
    endtask

    task automatic reset_dut(input int d, input int hold);
        exp_t e;
        rst_v[d]       = 1'b0;
        ref_md[d]      = 8'h00;
        md_known[d]    = 1'b1;
        ref_err_cyc[d] = -1;
        while (exp_q.size() > 0) e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            rd_v[d]  = 1'($urandom);
            wr_v[d]  = 1'($urandom);
            adr_v[d] = 8'($urandom);
            wd_v[d]  = 8'($urandom);
            tick();
        end
        idle(d);
        rst_v[d] = 1'b1;
    endtask

    // Drives a request now and records what the responder owes for it.
    task automatic start(input int d, input bit rd, input bit wr, input logic [7:0] a,
                         input logic [7:0] wdat, input bit differ);
        exp_t e;
        rd_v[d]  = rd;
        wr_v[d]  = wr;
        adr_v[d] = a;
        wd_v[d]  = wdat;
        e.dut     = d;
        e.due     = cyc + 1 + lat_of(d);
        e.is_read = rd && !wr;
        e.differ  = differ;
        e.data    = differ ? 8'h99 : ref_mem[d][a];
        if (wr) begin
            ref_mem[d][a] = wdat;
            ref_ok[d][a]  = 1'b1;
        end
        if (rd && wr && ref_err_cyc[d] < 0) ref_err_cyc[d] = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input int d, input bit scramble);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready_v[d]) return;
            if (scramble) begin
                adr_v[d] = 8'($urandom);
                wd_v[d]  = 8'($urandom);
            end
        end
        tests++;
        fails++;
        $display("FAIL ready_timeout dut=%0d got no ready within 40 cycles want ready", d);
    endtask

    task automatic txn(input int d, input bit rd, input bit wr, input logic [7:0] a,
                       input logic [7:0] wdat);
        start(d, rd, wr, a, wdat, 1'b0);
        wait_ready(d, 1'b0);
        idle(d);
        tick();
    endtask

    initial begin
        logic [7:0] a;
        int         op;
        tests = 0;
        fails = 0;
        rst_v = '0;
        rd_v  = '0;
        wr_v  = '0;
        adr_v = '0;
        wd_v  = '0;
        for (int d = 0; d < 3; d++) begin
            ref_md[d]      = 8'h00;
            md_known[d]    = 1'b1;
            ref_err_cyc[d] = -1;
            for (int i = 0; i < 256; i++) ref_ok[d][i] = 1'b0;
        end

        fork
            reset_dut(0, 6);
            reset_dut(1, 6);
            reset_dut(2, 6);
        join
        repeat (3) tick();

        // Write then read, latency 2, memdata held afterwards.
        txn(0, 1'b0, 1'b1, 8'h3C, 8'hA5);
        txn(0, 1'b1, 1'b0, 8'h3C, 8'h00);
        repeat (4) tick();

        // Latency 1, back-to-back requests including the top address.
        start(1, 1'b0, 1'b1, 8'h00, 8'h11, 1'b0);
        wait_ready(1, 1'b0);
        start(1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        wait_ready(1, 1'b0);
        start(1, 1'b0, 1'b1, 8'hFF, 8'h22, 1'b0);
        wait_ready(1, 1'b0);
        start(1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
        wait_ready(1, 1'b0);
        idle(1);
        tick();

        // Simultaneous read and write: write wins and err sticks.
        txn(1, 1'b1, 1'b1, 8'h05, 8'h77);
        txn(1, 1'b1, 1'b0, 8'h05, 8'h00);

        // Reset two cycles into a latency-4 write: nothing commits, no ready.
        rd_v[2]  = 1'b0;
        wr_v[2]  = 1'b1;
        adr_v[2] = 8'h10;
        wd_v[2]  = 8'h99;
        repeat (3) tick();
        reset_dut(2, 2);
        repeat (6) tick();
        txn(2, 1'b0, 1'b1, 8'h11, 8'h01);
        start(2, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1);
        wait_ready(2, 1'b0);
        idle(2);
        tick();

        // Address changes while waiting must not affect the latched read.
        txn(0, 1'b0, 1'b1, 8'h20, 8'h5A);
        txn(0, 1'b0, 1'b1, 8'h21, 8'hC3);
        start(0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
        tick();
        adr_v[0] = 8'h21;
        wd_v[0]  = 8'($urandom);
        wait_ready(0, 1'b0);
        idle(0);
        tick();

        // Randomised traffic against the reference array.
        for (int d = 0; d < 3; d++) begin
            wlist.delete();
            for (int n = 0; n < 40; n++) begin
                op = $urandom_range(0, 15);
                if (wlist.size() == 0 || op < 7) begin
                    a = (wlist.size() > 0 && op < 3) ? wlist[$urandom_range(0, wlist.size() - 1)]
                                                     : 8'($urandom);
                    wlist.push_back(a);
                    start(d, 1'b0, 1'b1, a, 8'($urandom), 1'b0);
                end else if (op == 15) begin
                    a = 8'($urandom);
                    wlist.push_back(a);
                    start(d, 1'b1, 1'b1, a, 8'($urandom), 1'b0);
                end else begin
                    a = wlist[$urandom_range(0, wlist.size() - 1)];
                    start(d, 1'b1, 1'b0, a, 8'($urandom), 1'b0);
                end
                wait_ready(d, 1'b1);
                if ($urandom_range(0, 2) != 0) begin
                    idle(d);
                    repeat ($urandom_range(1, 3)) tick();
                end
            end
            idle(d);
            repeat (3) tick();
        end

        repeat (6) tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_responses got %0d outstanding want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
